// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master/interconnect and ahb_slave_mem.
interface ahb_slave_mem_if #(
  parameter int ADDR_W = 8
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic              hready;
  logic              hreadyout;
  logic [31:0]       hrdata;
  logic              hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  hreadyout, hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hrdata, hresp
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a DEPTH x 32-bit register memory with byte-lane writes.
// Define AHB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states into every legal transfer.
module ahb_slave_mem #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           hclk,
  input  logic           hreset,
  ahb_slave_mem_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ERR1 = 2'd2;
  localparam logic [1:0] ERR2 = 2'd3;
`ifdef AHB_SLAVE_WAIT_EN
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACCEPT_NEXT = (WAIT_CYCLES == 0) ? IDLE : WAIT;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES - 1);
  logic [2:0] wait_cnt;
`endif

  logic [1:0]       state;
  logic             dp_valid;
  logic             dp_write;
  logic [IDX_W-1:0] dp_idx;
  logic [1:0]       dp_size;
  logic [1:0]       dp_lane;
  logic [31:0]      mem [DEPTH];

  logic       accept;
  logic       legal;
  logic       complete;
  logic [3:0] byte_en;

  assign bus.hreadyout = (state == IDLE) || (state == ERR2);
  assign bus.hresp     = (state == ERR1) || (state == ERR2);
  assign accept        = bus.hsel && bus.htrans[1] && bus.hready && bus.hreadyout;
  assign complete      = dp_valid && (state == IDLE);
  assign bus.hrdata    = (complete && !dp_write) ? mem[dp_idx] : 32'd0;

  always_comb begin
    legal = 1'b1;
    if (int'(bus.haddr[ADDR_W-1:2]) >= DEPTH)
      legal = 1'b0;
    if (bus.hsize > 3'd2)
      legal = 1'b0;
    if ((bus.hsize == 3'd1) && bus.haddr[0])
      legal = 1'b0;
    if ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00))
      legal = 1'b0;
  end

  always_comb begin
    byte_en = 4'b0000;
    case (dp_size)
      2'd0:    byte_en[dp_lane] = 1'b1;
      2'd1:    byte_en = dp_lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Illegal transfers never set dp_valid, so they can never reach the memory write port.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state    <= IDLE;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_size  <= 2'd0;
      dp_lane  <= 2'd0;
`ifdef AHB_SLAVE_WAIT_EN
      wait_cnt <= 3'd0;
`endif
    end else if (accept) begin
      dp_write <= bus.hwrite;
      dp_idx   <= bus.haddr[IDX_W+1:2];
      dp_size  <= bus.hsize[1:0];
      dp_lane  <= bus.haddr[1:0];
      if (legal) begin
        dp_valid <= 1'b1;
`ifdef AHB_SLAVE_WAIT_EN
        state    <= ACCEPT_NEXT;
        wait_cnt <= WAIT_INIT;
`else
        state    <= IDLE;
`endif
      end else begin
        dp_valid <= 1'b0;
        state    <= ERR1;
      end
    end else begin
      case (state)
        ERR1: state <= ERR2;
        ERR2: state <= IDLE;
`ifdef AHB_SLAVE_WAIT_EN
        WAIT: begin
          if (wait_cnt == 3'd0)
            state <= IDLE;
          else
            wait_cnt <= wait_cnt - 3'd1;
        end
`endif
        default: dp_valid <= 1'b0;
      endcase
    end
  end

  // Written data is visible to a read whose data phase starts on the following cycle.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 32'd0;
    end else if (complete && dp_write) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b])
          mem[dp_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed, table-driven bench for ahb_slave_mem; honours AHB_SLAVE_WAIT_EN for expected wait counts.
module tb_ahb_slave_mem;
  localparam int ADDR_W      = 8;
  localparam int DEPTH       = 16;
  localparam int WAIT_CYCLES = 2;
`ifdef AHB_SLAVE_WAIT_EN
  localparam int WT = WAIT_CYCLES;
`else
  localparam int WT = 0;
`endif

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mem_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.hready = bus.hreadyout;

  ahb_slave_mem #(
    .ADDR_W(ADDR_W),
    .DEPTH(DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .hclk(hclk),
    .hreset(hreset),
    .bus(bus)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic go_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd0;
    bus.haddr  = 8'h00;
  endtask

  task automatic drive_addr(input logic wr, input logic [7:0] addr, input logic [2:0] size);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.hwrite = wr;
    bus.haddr  = addr;
    bus.hsize  = size;
  endtask

  // Steps negedge by negedge until hreadyout is high, bounded; reports low cycles and the first low-cycle hresp.
  task automatic wait_ready(output int waits, output logic low_resp);
    waits = 0;
    low_resp = 1'b0;
    while (bus.hreadyout !== 1'b1 && waits < 16) begin
      if (waits == 0)
        low_resp = bus.hresp;
      waits++;
      @(negedge hclk);
    end
    if (bus.hreadyout !== 1'b1)
      check_output("ready_timeout", {31'd0, bus.hreadyout}, 32'd1);
  endtask

  task automatic apply_stimulus(input vec_t v, output logic [31:0] rdata, output logic resp,
                                output int waits, output logic low_resp);
    @(negedge hclk);
    drive_addr(v.wr, v.addr, v.size);
    @(negedge hclk);
    go_idle();
    bus.hwdata = v.wdata;
    wait_ready(waits, low_resp);
    rdata = bus.hrdata;
    resp  = bus.hresp;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[$];
    vec_t        rd;
    logic [31:0] rdata;
    logic        resp;
    logic        low_resp;
    int          waits;

    vecs.push_back(vec_t'{1'b1, 8'h04, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b0, 8'h04, 3'd2, 32'h0000_0000, 1'b0, 32'hDEADBEEF});
    vecs.push_back(vec_t'{1'b1, 8'h09, 3'd0, 32'hAAAAAAAA, 1'b0, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b0, 8'h08, 3'd2, 32'h0000_0000, 1'b0, 32'h0000AA00});
    vecs.push_back(vec_t'{1'b0, 8'h40, 3'd2, 32'h0000_0000, 1'b1, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b1, 8'h3C, 3'd2, 32'h11112222, 1'b0, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b0, 8'h3C, 3'd2, 32'h0000_0000, 1'b0, 32'h11112222});
    vecs.push_back(vec_t'{1'b1, 8'h40, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b1, 8'h0D, 3'd1, 32'hFFFFFFFF, 1'b1, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b1, 8'h02, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b1, 8'h00, 3'd3, 32'hFFFFFFFF, 1'b1, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b0, 8'h00, 3'd2, 32'h0000_0000, 1'b0, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b0, 8'h0C, 3'd2, 32'h0000_0000, 1'b0, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b1, 8'h0E, 3'd1, 32'hBEEF0000, 1'b0, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b1, 8'h0C, 3'd0, 32'h00000055, 1'b0, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b0, 8'h0C, 3'd2, 32'h0000_0000, 1'b0, 32'hBEEF0055});
    vecs.push_back(vec_t'{1'b0, 8'h06, 3'd1, 32'h0000_0000, 1'b0, 32'hDEADBEEF});
    vecs.push_back(vec_t'{1'b1, 8'h04, 3'd1, 32'h0000CAFE, 1'b0, 32'h0000_0000});
    vecs.push_back(vec_t'{1'b0, 8'h07, 3'd0, 32'h0000_0000, 1'b0, 32'hDEADCAFE});
    vecs.push_back(vec_t'{1'b0, 8'h08, 3'd2, 32'h0000_0000, 1'b0, 32'h0000AA00});

    go_idle();
    bus.hwdata = 32'd0;
    hreset = 1'b1;
    repeat (2) @(negedge hclk);
    check_output("reset_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    check_output("reset_hresp", {31'd0, bus.hresp}, 32'd0);
    check_output("reset_hrdata", bus.hrdata, 32'd0);
    hreset = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i], rdata, resp, waits, low_resp);
      check_output($sformatf("vec%0d_hresp", i), {31'd0, resp}, {31'd0, vecs[i].exp_resp});
      check_output($sformatf("vec%0d_hrdata", i), rdata, vecs[i].exp_rdata);
      check_output($sformatf("vec%0d_waits", i), 32'(waits), vecs[i].exp_resp ? 32'd1 : 32'(WT));
      if (waits > 0)
        check_output($sformatf("vec%0d_low_hresp", i), {31'd0, low_resp}, {31'd0, vecs[i].exp_resp});
    end

    // Non-selected and BUSY cycles must leave memory and the response untouched.
    @(negedge hclk);
    bus.hsel = 1'b0; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = 8'h3C; bus.hsize = 3'd2;
    bus.hwdata = 32'd0;
    @(negedge hclk);
    check_output("nosel_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    check_output("nosel_hresp", {31'd0, bus.hresp}, 32'd0);
    bus.hsel = 1'b1; bus.htrans = 2'b01;
    @(negedge hclk);
    check_output("busy_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    check_output("busy_hresp", {31'd0, bus.hresp}, 32'd0);
    go_idle();
    @(negedge hclk);
    check_output("busy_hreadyout_next", {31'd0, bus.hreadyout}, 32'd1);
    rd = vec_t'{1'b0, 8'h3C, 3'd2, 32'h0, 1'b0, 32'h11112222};
    apply_stimulus(rd, rdata, resp, waits, low_resp);
    check_output("ignored_mem", rdata, 32'h11112222);

    // Pipelined write then read to the same word.
    @(negedge hclk);
    drive_addr(1'b1, 8'h10, 3'd2);
    @(negedge hclk);
    bus.hwdata = 32'h12345678;
    drive_addr(1'b0, 8'h10, 3'd2);
    wait_ready(waits, low_resp);
    check_output("b2b_write_waits", 32'(waits), 32'(WT));
    check_output("b2b_write_hrdata", bus.hrdata, 32'd0);
    @(negedge hclk);
    go_idle();
    wait_ready(waits, low_resp);
    check_output("b2b_read_waits", 32'(waits), 32'(WT));
    check_output("b2b_read_hrdata", bus.hrdata, 32'h12345678);
    check_output("b2b_read_hresp", {31'd0, bus.hresp}, 32'd0);

    // Reset pulsed during a write's data phase.
    @(negedge hclk);
    drive_addr(1'b1, 8'h20, 3'd2);
    @(negedge hclk);
    go_idle();
    bus.hwdata = 32'hA5A5A5A5;
    hreset = 1'b1;
    #1;
    check_output("midreset_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    check_output("midreset_hresp", {31'd0, bus.hresp}, 32'd0);
    check_output("midreset_hrdata", bus.hrdata, 32'd0);
    @(negedge hclk);
    hreset = 1'b0;
    check_output("postreset_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
    rd = vec_t'{1'b0, 8'h20, 3'd2, 32'h0, 1'b0, 32'h0};
    apply_stimulus(rd, rdata, resp, waits, low_resp);
    check_output("postreset_target", rdata, 32'd0);
    check_output("postreset_waits", 32'(waits), 32'(WT));
    rd = vec_t'{1'b0, 8'h04, 3'd2, 32'h0, 1'b0, 32'h0};
    apply_stimulus(rd, rdata, resp, waits, low_resp);
    check_output("postreset_cleared", rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
